// File: rtl/phase_switch_ctrl.sv
// phase_switch_ctrl
// Generates four free-running divide-by-4 quadrature phase waves from clk and
// drives clk_out from the selected phase. A req/ack handshake moves clk_out to
// a new phase. During the move clk_out is parked low, so high pulses are never
// shortened and the low gap is at least MIN_LOW cycles.
module phase_switch_ctrl #(
    parameter int MIN_LOW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [1:0] phase_sel,
    output logic       ack,
    output logic       busy,
    output logic [1:0] cur_phase,
    output logic       clk_out,
    output logic       clk_0,
    output logic       clk_90,
    output logic       clk_180,
    output logic       clk_270
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [2:0] MIN_LOW_C = 3'(MIN_LOW);
    localparam logic [2:0] LOW_MAX   = 3'd7;

    logic [1:0] cnt_q, cnt_d;
    logic [1:0] state_q, state_d;
    logic [1:0] cur_q, cur_d;
    logic [1:0] tgt_q, tgt_d;
    logic       gate_q, gate_d;
    logic       armed_q, armed_d;
    logic [2:0] low_cnt_q, low_cnt_d;
    logic       ack_q, ack_d;
    logic       busy_q, busy_d;
    logic       clk_out_q, clk_out_d;
    logic [3:0] ph_q, ph_d;

    logic       accept;
    logic [1:0] drain_off;

    // Phase k is high for the two counter values k and k+1 (mod 4); the
    // wrapped 2-bit difference is 0 or 1 exactly when its upper bit is clear.
    function automatic logic phase_active(input logic [1:0] k, input logic [1:0] c);
        logic [1:0] diff;
        diff = c - k;
        return ~diff[1];
    endfunction

    // Switch sequencing: accept a request, drain to the old phase's fall,
    // hold clk_out low for at least MIN_LOW cycles, then release on the new phase.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        cur_d     = cur_q;
        tgt_d     = tgt_q;
        gate_d    = gate_q;
        low_cnt_d = low_cnt_q;
        ack_d     = 1'b0;
        accept    = req & armed_q;
        drain_off = cnt_q - cur_q;

        case (state_q)
            S_RUN: begin
                if (accept) begin
                    if (phase_sel == cur_q) begin
                        ack_d = 1'b1;
                    end else begin
                        tgt_d   = phase_sel;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // First low cycle of the current phase: close the gate here so
                // clk_out falls together with the old phase.
                if (drain_off == 2'd2) begin
                    gate_d    = 1'b0;
                    low_cnt_d = 3'd1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if ((low_cnt_q >= MIN_LOW_C) && (cnt_q == tgt_q)) begin
                    gate_d  = 1'b1;
                    cur_d   = tgt_q;
                    ack_d   = 1'b1;
                    state_d = S_RUN;
                end else if (low_cnt_q != LOW_MAX) begin
                    low_cnt_d = low_cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        busy_d = (state_d != S_RUN);

        // A completed request disarms; the requester re-arms by dropping req.
        if (ack_d) begin
            armed_d = 1'b0;
        end else if (!req) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end
    end

    // Phase counter and the next values of the registered clock outputs.
    always_comb begin
        cnt_d = cnt_q + 2'd1;
        for (int k = 0; k < 4; k++) begin
            ph_d[k] = phase_active(2'(k), cnt_q);
        end
        clk_out_d = gate_d & phase_active(cur_d, cnt_q);
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop reading the values
        // from before this edge, regardless of statement order.
        if (rst) begin
            cnt_q     <= 2'd0;
            state_q   <= S_RUN;
            cur_q     <= 2'd0;
            tgt_q     <= 2'd0;
            gate_q    <= 1'b1;
            armed_q   <= 1'b1;
            low_cnt_q <= 3'd0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            clk_out_q <= 1'b0;
            ph_q      <= 4'b0000;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            cur_q     <= cur_d;
            tgt_q     <= tgt_d;
            gate_q    <= gate_d;
            armed_q   <= armed_d;
            low_cnt_q <= low_cnt_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            clk_out_q <= clk_out_d;
            ph_q      <= ph_d;
        end
    end

    assign ack       = ack_q;
    assign busy      = busy_q;
    assign cur_phase = cur_q;
    assign clk_out   = clk_out_q;
    assign clk_0     = ph_q[0];
    assign clk_90    = ph_q[1];
    assign clk_180   = ph_q[2];
    assign clk_270   = ph_q[3];

endmodule

// File: tb/tb_phase_switch_ctrl.sv
// Bench for phase_switch_ctrl: three instances (MIN_LOW = 2, 1, 4) share one
// stimulus stream. A timing model predicts each switch's drain and completion
// cycles arithmetically; outputs are compared every cycle on the falling edge.
module tb_phase_switch_ctrl;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [1:0] phase_sel;

    logic       d_ack     [NI];
    logic       d_busy    [NI];
    logic [1:0] d_cur     [NI];
    logic       d_clk_out [NI];
    logic       d_c0      [NI];
    logic       d_c90     [NI];
    logic       d_c180    [NI];
    logic       d_c270    [NI];

    int n_vec  = 0;
    int n_fail = 0;

    // Model state
    int         mt;
    bit         mvalid = 1'b0;
    logic [3:0] e_ph;
    int         m_cur   [NI];
    bit         m_armed [NI];
    bit         m_sw    [NI];
    int         m_tgt   [NI];
    int         m_drain [NI];
    int         m_done  [NI];
    logic       e_ack     [NI];
    logic       e_busy    [NI];
    logic [1:0] e_cur     [NI];
    logic       e_clk_out [NI];

    // Monitor state
    int   ack_cnt  [NI];
    int   busy_cnt [NI];
    int   last_low [NI];
    int   ack_gap  [NI];
    logic ack_clk  [NI];
    int   run_len  [NI];
    logic run_val  [NI];
    bit   run_ok   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        phase_switch_ctrl #(
            .MIN_LOW(g == 0 ? 2 : (g == 1 ? 1 : 4))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .req      (req),
            .phase_sel(phase_sel),
            .ack      (d_ack[g]),
            .busy     (d_busy[g]),
            .cur_phase(d_cur[g]),
            .clk_out  (d_clk_out[g]),
            .clk_0    (d_c0[g]),
            .clk_90   (d_c90[g]),
            .clk_180  (d_c180[g]),
            .clk_270  (d_c270[g])
        );
    end

    initial forever #5 clk = ~clk;

    function automatic int ml_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
    endfunction

    function automatic bit phase_active(input int k, input int c);
        return ((c - k + 4) % 4) < 2;
    endfunction

    function automatic logic ph_of(input int i, input int k);
        case (k)
            0:       return d_c0[i];
            1:       return d_c90[i];
            2:       return d_c180[i];
            default: return d_c270[i];
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: on each edge, predict the registered outputs of the next cycle.
    initial begin
        int c;
        bit fire;
        forever begin
            @(posedge clk);
            if (rst) begin
                mt     = 0;
                mvalid = 1'b1;
                e_ph   = 4'b0000;
                for (int i = 0; i < NI; i++) begin
                    m_cur[i] = 0; m_armed[i] = 1'b1; m_sw[i] = 1'b0;
                    m_tgt[i] = 0; m_drain[i] = 0; m_done[i] = 0;
                    e_ack[i] = 1'b0; e_busy[i] = 1'b0; e_cur[i] = 2'd0; e_clk_out[i] = 1'b0;
                end
            end else if (mvalid) begin
                c = mt % 4;
                for (int k = 0; k < 4; k++) e_ph[k] = phase_active(k, c);
                for (int i = 0; i < NI; i++) begin
                    fire = 1'b0;
                    if (m_sw[i]) begin
                        if (mt == m_done[i]) begin
                            m_cur[i] = m_tgt[i];
                            m_sw[i]  = 1'b0;
                            fire     = 1'b1;
                        end
                    end else if (req && m_armed[i]) begin
                        if (int'(phase_sel) == m_cur[i]) begin
                            fire = 1'b1;
                        end else begin
                            m_sw[i]    = 1'b1;
                            m_tgt[i]   = int'(phase_sel);
                            // Gate closes in the first later cycle where the old phase goes low.
                            m_drain[i] = mt + 1;
                            while (((m_drain[i] - m_cur[i] + 4) % 4) != 2) m_drain[i]++;
                            // Release: low for at least MIN_LOW cycles and aligned to the target.
                            m_done[i]  = m_drain[i] + ml_of(i);
                            while ((m_done[i] % 4) != m_tgt[i]) m_done[i]++;
                        end
                    end
                    if (fire) m_armed[i] = 1'b0;
                    else if (!req) m_armed[i] = 1'b1;
                    e_ack[i]     = fire;
                    e_busy[i]    = m_sw[i];
                    e_cur[i]     = 2'(m_cur[i]);
                    e_clk_out[i] = !(m_sw[i] && (mt >= m_drain[i])) && phase_active(m_cur[i], c);
                end
                mt++;
            end
        end
    end

    // Compare process: every cycle, away from the rising edge.
    initial begin
        int lim;
        for (int i = 0; i < NI; i++) begin
            ack_cnt[i] = 0; busy_cnt[i] = 0; last_low[i] = 0; ack_gap[i] = 0;
            ack_clk[i] = 1'b0; run_len[i] = 0; run_val[i] = 1'b0; run_ok[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            if (mvalid) begin
                for (int i = 0; i < NI; i++) begin
                    for (int k = 0; k < 4; k++)
                        check($sformatf("u%0d clk_%0d", i, k * 90), ph_of(i, k), e_ph[k]);
                    check($sformatf("u%0d ack", i), d_ack[i], e_ack[i]);
                    check($sformatf("u%0d busy", i), d_busy[i], e_busy[i]);
                    check($sformatf("u%0d cur_phase", i), d_cur[i], e_cur[i]);
                    check($sformatf("u%0d clk_out", i), d_clk_out[i], e_clk_out[i]);

                    // Run-length tracking of clk_out (runs cut by reset are not judged).
                    if (rst) begin
                        run_ok[i]  = 1'b0;
                        run_val[i] = d_clk_out[i];
                        run_len[i] = 1;
                    end else if (d_clk_out[i] === run_val[i]) begin
                        run_len[i]++;
                    end else begin
                        if (run_ok[i]) begin
                            lim = run_val[i] ? 2 : ((ml_of(i) < 2) ? ml_of(i) : 2);
                            check($sformatf("u%0d min_run_%0d", i, run_val[i]), run_len[i] >= lim, 1);
                        end
                        if (!run_val[i]) last_low[i] = run_len[i];
                        run_ok[i]  = 1'b1;
                        run_val[i] = d_clk_out[i];
                        run_len[i] = 1;
                    end

                    if (d_ack[i] === 1'b1) begin
                        ack_cnt[i]++;
                        ack_gap[i] = last_low[i];
                        ack_clk[i] = d_clk_out[i];
                    end
                    if (d_busy[i] === 1'b1) busy_cnt[i]++;
                end
            end
        end
    end

    // All tasks below are entered and left just after a falling edge.
    task automatic wait_all_acked(input int base0, input int base1, input int base2, input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            @(negedge clk); #1;
            done = (ack_cnt[0] > base0) && (ack_cnt[1] > base1) && (ack_cnt[2] > base2);
        end
        check(name, done, 1);
    endtask

    task automatic do_switch(input logic [1:0] sel, input int g0, input int g1, input int g2);
        int base [NI];
        int gexp [NI];
        gexp = '{g0, g1, g2};
        for (int i = 0; i < NI; i++) base[i] = ack_cnt[i];
        req       = 1'b1;
        phase_sel = sel;
        wait_all_acked(base[0], base[1], base[2], $sformatf("switch_to_%0d_done", sel));
        req = 1'b0;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d gap_to_%0d", i, sel), ack_gap[i], gexp[i]);
            check($sformatf("u%0d clk_out_at_ack", i), ack_clk[i], 1);
            check($sformatf("u%0d cur_after_%0d", i, sel), d_cur[i], sel);
            check($sformatf("u%0d ack_count", i), ack_cnt[i], base[i] + 1);
        end
        repeat (2) begin @(negedge clk); #1; end
    endtask

    task automatic wait_busy();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk); #1;
            seen = (d_busy[0] === 1'b1);
        end
        check("busy_rise", seen, 1);
    endtask

    initial begin
        logic [15:0] p0, p90, p180, p270;
        logic [15:0] pout [NI];
        int base [NI];
        int bbase [NI];

        rst       = 1'b1;
        req       = 1'b0;
        phase_sel = 2'd0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // Free run from reset: cycle t recorded in bit t.
        for (int t = 0; t < 16; t++) begin
            if (t > 0) begin @(negedge clk); #1; end
            p0[t] = d_c0[0]; p90[t] = d_c90[0]; p180[t] = d_c180[0]; p270[t] = d_c270[0];
            for (int i = 0; i < NI; i++) pout[i][t] = d_clk_out[i];
        end
        check("clk_0 pattern", p0, 16'h6666);
        check("clk_90 pattern", p90, 16'hCCCC);
        check("clk_180 pattern", p180, 16'h9998);
        check("clk_270 pattern", p270, 16'h3332);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d clk_out pattern", i), pout[i], 16'h6666);
            check($sformatf("u%0d cur_phase reset", i), d_cur[i], 0);
        end

        // Switches from phase 0; expected gaps listed for MIN_LOW = 2, 1, 4.
        do_switch(2'd2, 4, 4, 4);
        do_switch(2'd0, 4, 4, 4);
        do_switch(2'd1, 3, 3, 7);
        do_switch(2'd0, 5, 1, 5);
        do_switch(2'd3, 5, 1, 5);
        do_switch(2'd0, 3, 3, 7);

        // Same-phase request held for several cycles.
        for (int i = 0; i < NI; i++) begin base[i] = ack_cnt[i]; bbase[i] = busy_cnt[i]; end
        req       = 1'b1;
        phase_sel = 2'd0;
        @(negedge clk); #1;
        for (int i = 0; i < NI; i++) check($sformatf("u%0d same_phase_ack", i), d_ack[i], 1);
        repeat (5) begin @(negedge clk); #1; end
        req = 1'b0;
        repeat (2) begin @(negedge clk); #1; end
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d same_phase_ack_count", i), ack_cnt[i], base[i] + 1);
            check($sformatf("u%0d same_phase_busy", i), busy_cnt[i], bbase[i]);
        end

        // Drop req and change phase_sel mid-switch: switch still completes to 2.
        for (int i = 0; i < NI; i++) base[i] = ack_cnt[i];
        req       = 1'b1;
        phase_sel = 2'd2;
        wait_busy();
        repeat (4) begin @(negedge clk); #1; end
        req       = 1'b0;
        phase_sel = 2'd3;
        wait_all_acked(base[0], base[1], base[2], "dropped_req_done");
        repeat (5) begin @(negedge clk); #1; end
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d dropped_req_cur", i), d_cur[i], 2);
            check($sformatf("u%0d dropped_req_acks", i), ack_cnt[i], base[i] + 1);
        end

        do_switch(2'd0, 4, 4, 4);

        // Reset in the middle of a 0->2 switch.
        for (int i = 0; i < NI; i++) base[i] = ack_cnt[i];
        req       = 1'b1;
        phase_sel = 2'd2;
        wait_busy();
        repeat (4) begin @(negedge clk); #1; end
        rst = 1'b1;
        req = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d rst_ack", i), d_ack[i], 0);
            check($sformatf("u%0d rst_busy", i), d_busy[i], 0);
            check($sformatf("u%0d rst_cur", i), d_cur[i], 0);
            check($sformatf("u%0d rst_clk_out", i), d_clk_out[i], 0);
            check($sformatf("u%0d rst_clk_0", i), d_c0[i], 0);
        end
        repeat (10) begin @(negedge clk); #1; end
        for (int i = 0; i < NI; i++)
            check($sformatf("u%0d no_ack_after_abort", i), ack_cnt[i], base[i]);

        // Random requester, occasional reset.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); #1;
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                @(negedge clk); #1;
                rst = 1'b0;
            end
            if (req) begin
                if ($urandom_range(0, 5) == 0) req = 1'b0;
            end else begin
                phase_sel = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) req = 1'b1;
            end
        end
        req = 1'b0;
        repeat (12) begin @(negedge clk); #1; end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
